// File: rtl/nexys_starship_pkg.sv
// Shared constants for the Nexys starship repair logic: room indices,
// arbiter state encoding and the default per-grant timeout.
package nexys_starship_pkg;

  localparam logic [1:0] ROOM_TOP   = 2'd0;
  localparam logic [1:0] ROOM_BTM   = 2'd1;
  localparam logic [1:0] ROOM_LEFT  = 2'd2;
  localparam logic [1:0] ROOM_RIGHT = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam int DEFAULT_TIMEOUT_TICKS = 8;

  function automatic logic [3:0] room_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/nexys_starship_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping from room 3 back to room 0.
module nexys_starship_rr_pick
  import nexys_starship_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       vld_o,
  output logic [1:0] idx_o
);

  // Scan the farthest offset first so the nearest requester overwrites it.
  always_comb begin
    vld_o = 1'b0;
    idx_o = ptr_i;
    for (int i = 3; i >= 0; i--) begin
      if (req_i[ptr_i + 2'(i)]) begin
        vld_o = 1'b1;
        idx_o = ptr_i + 2'(i);
      end
    end
  end

endmodule

// File: rtl/nexys_starship_repair_arbiter.sv
// Repair console arbiter: grants the Sw/BtnU console to one broken room at a
// time. Define NEXYS_STARSHIP_ARB_PRIORITY_EN for fixed top>btm>left>right.
module nexys_starship_repair_arbiter
  import nexys_starship_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  input  logic       submit_pulse,
  input  logic [3:0] hex_in,
  input  logic       timer_tick,
  input  logic       gameover,
  output logic [3:0] grant,
  output logic [3:0] submit_out,
  output logic [3:0] hex_out,
  output logic [1:0] active_idx,
  output logic       busy,
  output logic [3:0] timeout_err
);

  localparam logic [3:0] TIMEOUT_LIM = 4'(TIMEOUT_TICKS);

  logic [1:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] sub_q, sub_d;
  logic [3:0] hex_q, hex_d;
  logic [1:0] idx_q, idx_d;
  logic       busy_q, busy_d;
  logic [3:0] to_q, to_d;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [3:0] cnt_inc;
  logic       owner_exit;
  logic       to_hit;

`ifdef NEXYS_STARSHIP_ARB_PRIORITY_EN
  always_comb begin
    win_vld = |req;
    win_idx = ROOM_RIGHT;
    if (req[ROOM_LEFT]) win_idx = ROOM_LEFT;
    if (req[ROOM_BTM])  win_idx = ROOM_BTM;
    if (req[ROOM_TOP])  win_idx = ROOM_TOP;
  end
`else
  nexys_starship_rr_pick u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .vld_o (win_vld),
    .idx_o (win_idx)
  );
`endif

  assign cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign owner_exit = done[idx_q] | ~req[idx_q];
  assign to_hit     = timer_tick & (cnt_inc >= TIMEOUT_LIM);

  // All outputs are registered; the _d values describe the next cycle's outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = 4'b0000;
    sub_d   = 4'b0000;
    hex_d   = 4'h0;
    idx_d   = idx_q;
    busy_d  = 1'b0;
    to_d    = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (!gameover && win_vld) begin
          state_d = ST_SERVE;
          grant_d = room_onehot(win_idx);
          idx_d   = win_idx;
          busy_d  = 1'b1;
          hex_d   = hex_in;
          cnt_d   = 4'd0;
        end
      end
      ST_SERVE: begin
        if (gameover) begin
          state_d = ST_IDLE;
        end else if (owner_exit) begin
          // done beats a simultaneous timeout, so no error here.
          state_d = ST_RELEASE;
          ptr_d   = idx_q + 2'd1;
        end else if (to_hit) begin
          state_d = ST_RELEASE;
          ptr_d   = idx_q + 2'd1;
          to_d    = room_onehot(idx_q);
        end else begin
          grant_d = grant_q;
          busy_d  = 1'b1;
          hex_d   = hex_in;
          sub_d   = submit_pulse ? grant_q : 4'b0000;
          if (timer_tick) cnt_d = cnt_inc;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      grant_q <= 4'b0000;
      sub_q   <= 4'b0000;
      hex_q   <= 4'h0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      to_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sub_q   <= sub_d;
      hex_q   <= hex_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  assign grant       = grant_q;
  assign submit_out  = sub_q;
  assign hex_out     = hex_q;
  assign active_idx  = idx_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_nexys_starship_repair_arbiter.sv
// Directed scoreboard bench for the repair console arbiter (round-robin build,
// TIMEOUT_TICKS=3).
module tb_nexys_starship_repair_arbiter;

  logic       board_clk = 1'b0;
  logic       Reset;
  logic [3:0] req, done, hex_in;
  logic       submit_pulse, timer_tick, gameover;
  logic [3:0] grant, submit_out, hex_out, timeout_err;
  logic [1:0] active_idx;
  logic       busy;

  nexys_starship_repair_arbiter #(.TIMEOUT_TICKS(3)) dut (
    .board_clk    (board_clk),
    .Reset        (Reset),
    .req          (req),
    .done         (done),
    .submit_pulse (submit_pulse),
    .hex_in       (hex_in),
    .timer_tick   (timer_tick),
    .gameover     (gameover),
    .grant        (grant),
    .submit_out   (submit_out),
    .hex_out      (hex_out),
    .active_idx   (active_idx),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 board_clk = ~board_clk;

  typedef struct {
    string      nm;
    logic [3:0] g;
    logic [3:0] so;
    logic [3:0] hx;
    logic [1:0] ai;
    logic       b;
    logic [3:0] to;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor: pops the expectation pushed in the preceding half cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge board_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if ({grant, submit_out, hex_out, active_idx, busy, timeout_err} !==
            {e.g, e.so, e.hx, e.ai, e.b, e.to}) begin
          fails++;
          $display("FAIL %s: got grant=%b sub=%b hex=%h idx=%0d busy=%b to=%b, want grant=%b sub=%b hex=%h idx=%0d busy=%b to=%b",
                   e.nm, grant, submit_out, hex_out, active_idx, busy, timeout_err,
                   e.g, e.so, e.hx, e.ai, e.b, e.to);
        end
      end
    end
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: wait expired before stimulus completed");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic step(input string nm, input logic [3:0] g, input logic [3:0] so,
                      input logic [3:0] hx, input logic [1:0] ai, input logic b,
                      input logic [3:0] to);
    exp_t e;
    e.nm = nm; e.g = g; e.so = so; e.hx = hx; e.ai = ai; e.b = b; e.to = to;
    q.push_back(e);
    @(negedge board_clk);
    done = 4'b0000;
    submit_pulse = 1'b0;
    timer_tick = 1'b0;
  endtask

  initial begin
    logic [1:0] order [4];
    logic [1:0] cur;
    order = '{2'd3, 2'd0, 2'd1, 2'd2};

    Reset = 1'b1;
    req = 4'b0101; done = 4'b0000; hex_in = 4'h0;
    submit_pulse = 1'b0; timer_tick = 1'b0; gameover = 1'b0;
    @(negedge board_clk);
    @(negedge board_clk);
    tests++;
    if ({grant, submit_out, hex_out, active_idx, busy, timeout_err} !== 19'd0) begin
      fails++;
      $display("FAIL reset_state: grant=%b sub=%b hex=%h idx=%0d busy=%b to=%b",
               grant, submit_out, hex_out, active_idx, busy, timeout_err);
    end
    step("rst", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0, 4'b0000);

    Reset = 1'b0;
    step("first_grant", 4'b0001, 4'b0000, 4'h0, 2'd0, 1'b1, 4'b0000);
    hex_in = 4'hA; submit_pulse = 1'b1;
    step("submit", 4'b0001, 4'b0001, 4'hA, 2'd0, 1'b1, 4'b0000);
    done = 4'b0001;
    step("done_rel", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0, 4'b0000);
    step("rel_idle", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0, 4'b0000);
    step("grant_left", 4'b0100, 4'b0000, 4'hA, 2'd2, 1'b1, 4'b0000);
    req = 4'b1111; hex_in = 4'h3;
    step("hold", 4'b0100, 4'b0000, 4'h3, 2'd2, 1'b1, 4'b0000);

    cur = 2'd2;
    for (int k = 0; k < 4; k++) begin
      done[cur] = 1'b1;
      step("rr_rel", 4'b0000, 4'b0000, 4'h0, cur, 1'b0, 4'b0000);
      step("rr_idle", 4'b0000, 4'b0000, 4'h0, cur, 1'b0, 4'b0000);
      step("rr_grant", 4'b0001 << order[k], 4'b0000, 4'h3, order[k], 1'b1, 4'b0000);
      cur = order[k];
    end

    // Owner is room 2; third tick expires the grant, submit on that cycle is dropped.
    timer_tick = 1'b1;
    step("to_t1", 4'b0100, 4'b0000, 4'h3, 2'd2, 1'b1, 4'b0000);
    timer_tick = 1'b1;
    step("to_t2", 4'b0100, 4'b0000, 4'h3, 2'd2, 1'b1, 4'b0000);
    timer_tick = 1'b1; submit_pulse = 1'b1;
    step("to_exit", 4'b0000, 4'b0000, 4'h0, 2'd2, 1'b0, 4'b0100);
    step("to_rel", 4'b0000, 4'b0000, 4'h0, 2'd2, 1'b0, 4'b0000);
    step("to_next", 4'b1000, 4'b0000, 4'h3, 2'd3, 1'b1, 4'b0000);

    timer_tick = 1'b1;
    step("dt_t1", 4'b1000, 4'b0000, 4'h3, 2'd3, 1'b1, 4'b0000);
    timer_tick = 1'b1;
    step("dt_t2", 4'b1000, 4'b0000, 4'h3, 2'd3, 1'b1, 4'b0000);
    timer_tick = 1'b1; done = 4'b1000;
    step("dt_exit", 4'b0000, 4'b0000, 4'h0, 2'd3, 1'b0, 4'b0000);
    submit_pulse = 1'b1;
    step("sub_rel", 4'b0000, 4'b0000, 4'h0, 2'd3, 1'b0, 4'b0000);
    submit_pulse = 1'b1;
    step("sub_idle", 4'b0001, 4'b0000, 4'h3, 2'd0, 1'b1, 4'b0000);
    submit_pulse = 1'b1; hex_in = 4'h5;
    step("sub_serve", 4'b0001, 4'b0001, 4'h5, 2'd0, 1'b1, 4'b0000);
    step("sub_once", 4'b0001, 4'b0000, 4'h5, 2'd0, 1'b1, 4'b0000);

    gameover = 1'b1;
    step("go_drop", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0, 4'b0000);
    step("go_hold1", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0, 4'b0000);
    req = 4'b1110;
    step("go_hold2", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0, 4'b0000);
    gameover = 1'b0;
    step("go_resume", 4'b0010, 4'b0000, 4'h5, 2'd1, 1'b1, 4'b0000);

    req = 4'b1100;
    step("drop_rel", 4'b0000, 4'b0000, 4'h0, 2'd1, 1'b0, 4'b0000);
    step("drop_idle", 4'b0000, 4'b0000, 4'h0, 2'd1, 1'b0, 4'b0000);
    step("drop_grant", 4'b0100, 4'b0000, 4'h5, 2'd2, 1'b1, 4'b0000);

    Reset = 1'b1;
    step("rst_mid", 4'b0000, 4'b0000, 4'h0, 2'd0, 1'b0, 4'b0000);

    @(negedge board_clk);
    @(negedge board_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nexys_starship_repair_arbiter.md
# nexys_starship_repair_arbiter

Shares the single operator repair console among the four room repair state machines (TR, BR, LR, RR). The console is the Sw3..Sw0 hex combo, the BtnU submit pulse and the SSD repair digit. The block sits between the debounced inputs and the repair SMs. It grants the console to one broken room at a time, routes combo and submit to that room only, and reclaims the console when the room is repaired, stops requesting, times out, or the game ends.

## Interface
Parameters:
- TIMEOUT_TICKS, default 8: timer_tick strobes allowed per grant before a forced release (valid range 1..15).

Ports:
- board_clk, in, 1: system clock, 100 MHz.
- Reset, in, 1: asynchronous, active-high.
- req, in, 4: broken flags, bit0=top, bit1=btm, bit2=left, bit3=right.
- done, in, 4: one-cycle "repair accepted" pulse from each room SM.
- submit_pulse, in, 1: debounced single-cycle BtnU pulse.
- hex_in, in, 4: switch combo {Sw3,Sw2,Sw1,Sw0}.
- timer_tick, in, 1: one-cycle strobe, about 3 Hz (a DIV_CLK[24] edge).
- gameover, in, 1: level; while high, no grants are issued.
- grant, out, 4: one-hot console owner, or 0.
- submit_out, out, 4: one-cycle submit routed to the owner.
- hex_out, out, 4: registered combo while granted, else 0.
- active_idx, out, 2: owner index for the SSD mux; holds its last value when idle.
- busy, out, 1: high in SERVE.
- timeout_err, out, 4: one-cycle pulse on the room whose grant expired.

## Operation
- Reset values: every output is 0. State is IDLE, rotation pointer is 0, tick counter is 0.
- IDLE: the winner is picked from the current req. The next cycle is SERVE with grant=onehot(winner), active_idx=winner and the counter cleared.
- Round-robin selection: search starts at the pointer and wraps 3→0. The pointer is set to served index+1 (mod 4) on every release.
- SERVE, exit conditions:
  - done[idx]=1 or req[idx]=0: go to RELEASE, no error.
  - Counter reaches TIMEOUT_TICKS on a timer_tick: go to RELEASE and pulse timeout_err[idx] for one cycle.
  - done and timeout in the same cycle: done wins, no error.
- While in SERVE:
  - The counter increments on each timer_tick and saturates at 15.
  - submit_pulse produces submit_out=grant on the next cycle, for one cycle.
  - A submit in the same cycle as an exit condition is dropped.
- RELEASE: one cycle with grant=0, hex_out=0 and busy=0. Then go to IDLE. This guarantees a dead cycle between owners.
- A submit_pulse in IDLE or RELEASE is discarded; nothing is queued.
- gameover=1 in any state:
  - Next cycle is IDLE. grant, submit_out and hex_out are 0. No timeout_err is pulsed. The pointer is unchanged.
  - The block stays in IDLE until gameover falls.
- Requests from other rooms arriving during SERVE wait; there is no preemption.

## Timing
- Request to grant: 1 cycle when in IDLE. A request first seen during SERVE is granted at the earliest 2 cycles after the current exit (RELEASE, then IDLE).
- submit_pulse to submit_out: 1 cycle, registered.
- hex_in to hex_out: 1 cycle, registered, sampled every cycle in SERVE.
- Exit condition to grant=0: 1 cycle.
- Timeout latency: the grant drops on the cycle after the TIMEOUT_TICKS-th timer_tick, counted from grant.
- Every output is a flop output; no combinational input-to-output path exists.

## Configuration
- NEXYS_STARSHIP_ARB_PRIORITY_EN defined: fixed priority top > btm > left > right. The pointer is still maintained but ignored.
- Macro undefined (default): round-robin as described in Operation.
- All timing and state behaviour is identical in both builds.

## Structure
- Shared package nexys_starship_pkg holds:
  - Room index constants ROOM_TOP=0, ROOM_BTM=1, ROOM_LEFT=2, ROOM_RIGHT=3.
  - The state encoding IDLE/SERVE/RELEASE, 2-bit.
  - The default timeout constant.
- One sub-module: nexys_starship_rr_pick. It is combinational, takes a 4-bit req and a 2-bit pointer, and returns a valid flag and a 2-bit index. The priority build bypasses it.

## Test plan
- Reset with req=4'b0101 → all outputs 0. After Reset falls, grant=4'b0001 one cycle later and active_idx=0.
- Grant top, pulse submit with hex_in=4'hA → submit_out=4'b0001 one cycle later and hex_out=4'hA. Then done[0] → one RELEASE cycle, then grant=4'b0100.
- req=4'b1111 with each owner releasing via done → grant order 0,1,2,3,0. With NEXYS_STARSHIP_ARB_PRIORITY_EN defined and req held, the grant returns to 0 each time.
- TIMEOUT_TICKS=3, no done → grant drops after the third timer_tick, timeout_err=4'b0001 for one cycle, and the next room is granted.
- done[idx] and the final timer_tick in the same cycle → no timeout_err. Separately, submit_pulse while IDLE → submit_out stays 0.
- gameover rises mid-SERVE → grant=0 next cycle with no error. It stays idle with req≠0 until gameover falls, then the next room after the pointer is granted.
